mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles to wait for dvalid before aborting an access.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rstn  in  1  reset; synchronous, active-high (1 = reset).
REQ-004 SHALL have port enable  in  1  start strobe, sampled only in IDLE.
REQ-005 SHALL have port fin  out  1  one-cycle completion pulse.
REQ-006 SHALL have port inst  in  Inst  decoded instruction, captured at start.
REQ-007 SHALL have port inst_out  out  Inst  registered copy of the captured inst, for the write stage.
REQ-008 SHALL have port alu_result  in  32  byte address for memory ops, or the pass-through value otherwise.
REQ-009 SHALL have port store_data  in  32  store source value.
REQ-010 SHALL have ports mem_read / mem_write  in  1 each  load / store request.
REQ-011 SHALL have port mem_size  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-012 SHALL have port mem_unsigned  in  1  load zero-extends when 1 and sign-extends when 0.
REQ-013 SHALL have port regwdata_out  out  32  value handed to the write stage as regwdata_in.
REQ-014 SHALL have port misaligned  out  1  set with fin when the access is misaligned.
REQ-015 SHALL have port timeout  out  1  set with fin when the bus does not respond in time.
REQ-016 SHALL have bus ports dreq out 1, dwe out 1, daddr out 32 (word-aligned, low two bits 0), dwdata out 32, dbe out 4, dvalid in 1, drdata in 32.

Function
REQ-017 SHALL implement the FSM states IDLE, REQ, DONE.
REQ-018 SHALL, in IDLE with enable=1, capture inst, alu_result, store_data, mem_read, mem_write, mem_size and mem_unsigned into internal registers.
REQ-019 SHALL, when neither mem op is set, go IDLE->DONE and set regwdata_out=alu_result, giving fin exactly 1 cycle after enable.
REQ-020 SHALL treat an access as misaligned for half with addr[0]=1, or word with addr[1:0]!=0.
REQ-021 SHALL, on a misaligned access, go IDLE->DONE with no dreq, misaligned=1 and regwdata_out=0.
REQ-022 SHALL, on an aligned mem op, go IDLE->REQ and hold dreq=1 with stable daddr, dwe, dwdata and dbe until dvalid=1 is sampled.
REQ-023 SHALL, on sampling dvalid=1 in REQ, go to DONE and drop dreq on the next cycle, so fin is asserted the cycle after dvalid.
REQ-024 SHALL, when mem_read and mem_write are both 1, perform a store only.
REQ-025 SHALL, on a store, drive dwe=1 and dwdata with store_data replicated (byte x4, half x2, word as-is).
REQ-026 SHALL set dbe as follows: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-027 SHALL, on a store, set regwdata_out=0.
REQ-028 SHALL, on a load, drive dwe=0 and dbe=1111, and select the lane drdata[8*addr[1:0] +: 8] for byte or drdata[16*addr[1] +: 16] for half.
REQ-029 SHALL extend the selected load data per mem_unsigned and register it into regwdata_out on the dvalid cycle.
REQ-030 SHALL count cycles spent in REQ (8-bit saturating counter, or wider if TIMEOUT_CYCLES > 255).
REQ-031 SHALL, when the REQ cycle count reaches TIMEOUT_CYCLES without dvalid, go to DONE with timeout=1 and regwdata_out=0, and drop dreq.
REQ-032 SHALL assert fin, misaligned and timeout for exactly one cycle in DONE, then return to IDLE.
REQ-033 SHALL hold regwdata_out and inst_out stable until the next capture.
REQ-034 SHALL ignore enable while in REQ or DONE.
REQ-035 SHALL ignore dvalid outside REQ.
REQ-036 SHALL accept enable in the same cycle it returns to IDLE after DONE, i.e. issue back-to-back with a minimum of 2 cycles per op.
REQ-037 SHALL, when dvalid arrives in the same cycle the timeout is reached, take dvalid (successful completion, timeout=0).

Reset
REQ-038 SHALL, with rstn=1 at a clock edge, force state IDLE and clear the REQ cycle counter.
REQ-039 SHALL, with rstn=1 at a clock edge, set fin=0, dreq=0, dwe=0, dbe=0, daddr=0, dwdata=0, regwdata_out=0, misaligned=0, timeout=0, and inst_out to all zeros.
REQ-040 SHALL, on reset during REQ, drop dreq at that edge and discard the pending access; a late dvalid SHALL have no effect.

Verification
REQ-041 SHALL cover a non-mem op: alu_result=0x12345678, enable -> fin 1 cycle later, regwdata_out=0x12345678, dreq never 1.
REQ-042 SHALL cover a signed byte load: addr=0x103, drdata=0x80AABBCC, dvalid after 3 cycles -> daddr=0x100, regwdata_out=0xFFFFFF80, fin 1 cycle after dvalid.
REQ-043 SHALL cover a half store: addr=0x202, store_data=0x0000BEEF -> dwe=1, dbe=1100, dwdata=0xBEEFBEEF, daddr=0x200, regwdata_out=0.
REQ-044 SHALL cover a misaligned word load: addr=0x101 -> no dreq, fin 1 cycle after enable, misaligned=1, regwdata_out=0.
REQ-045 SHALL cover a timeout: TIMEOUT_CYCLES=4, dvalid held 0 -> dreq high 4 cycles, then fin with timeout=1.
REQ-046 SHALL cover reset mid-op: rstn pulsed during REQ, then dvalid -> dreq=0 after the reset edge, no fin, state IDLE, new enable accepted.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Memory-access pipeline stage. Captures one operation on enable,
//               drives a single-beat request/valid data bus (aligned loads and
//               stores), and reports completion with a one-cycle fin pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int INST_W         = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enable,
    output logic              fin,
    input  logic [INST_W-1:0] inst,
    output logic [INST_W-1:0] inst_out,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       store_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    output logic [31:0]       regwdata_out,
    output logic              misaligned,
    output logic              timeout,
    output logic              dreq,
    output logic              dwe,
    output logic [31:0]       daddr,
    output logic [31:0]       dwdata,
    output logic [3:0]        dbe,
    input  logic              dvalid,
    input  logic [31:0]       drdata
);

    localparam int c_CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [c_CNT_W-1:0] c_LIMIT = TIMEOUT_CYCLES[c_CNT_W-1:0];

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    logic [1:0]         state_q,   state_d;
    logic [c_CNT_W-1:0] cnt_q,     cnt_d;
    logic [1:0]         addr_lo_q, addr_lo_d;
    logic [1:0]         size_q,    size_d;
    logic               uns_q,     uns_d;
    logic               store_q,   store_d;

    logic               fin_q,     fin_d;
    logic               mis_q,     mis_d;
    logic               to_q,      to_d;
    logic [31:0]        regw_q,    regw_d;
    logic [INST_W-1:0]  inst_q,    inst_d;

    logic               dreq_q,    dreq_d;
    logic               dwe_q,     dwe_d;
    logic [31:0]        daddr_q,   daddr_d;
    logic [31:0]        dwdata_q,  dwdata_d;
    logic [3:0]         dbe_q,     dbe_d;

    // ------------------------------------------------------------------
    // Capture-side decode (operates on the live inputs in IDLE)
    // ------------------------------------------------------------------
    logic               w_is_mem;
    logic               w_is_byte;
    logic               w_is_half;
    logic               w_is_word;
    logic               w_misal;
    logic [31:0]        w_st_data;
    logic [3:0]         w_st_be;

    assign w_is_mem  = mem_read | mem_write;
    assign w_is_byte = (mem_size == c_SZ_BYTE);
    assign w_is_half = (mem_size == c_SZ_HALF);
    assign w_is_word = ~w_is_byte & ~w_is_half;
    assign w_misal   = (w_is_half & alu_result[0]) | (w_is_word & (|alu_result[1:0]));

    always_comb begin
        w_st_data = store_data;
        w_st_be   = 4'b1111;
        if (w_is_byte) begin
            w_st_data = {4{store_data[7:0]}};
            w_st_be   = 4'b0001 << alu_result[1:0];
        end else if (w_is_half) begin
            w_st_data = {2{store_data[15:0]}};
            w_st_be   = 4'b0011 << alu_result[1:0];
        end
    end

    // ------------------------------------------------------------------
    // Response-side lane select and extension (uses captured attributes)
    // ------------------------------------------------------------------
    logic [7:0]         w_ld_byte;
    logic [15:0]        w_ld_half;
    logic [31:0]        w_ld_val;

    assign w_ld_byte = drdata[{addr_lo_q, 3'b000} +: 8];
    assign w_ld_half = drdata[{addr_lo_q[1], 4'b0000} +: 16];

    always_comb begin
        w_ld_val = drdata;
        if (size_q == c_SZ_BYTE) begin
            w_ld_val = uns_q ? {24'h000000, w_ld_byte} : {{24{w_ld_byte[7]}}, w_ld_byte};
        end else if (size_q == c_SZ_HALF) begin
            w_ld_val = uns_q ? {16'h0000, w_ld_half} : {{16{w_ld_half[15]}}, w_ld_half};
        end
    end

    // Cycle count including the current one; widened by a bit so saturation is visible.
    logic [c_CNT_W:0]   w_cnt_inc;
    logic               w_limit_hit;

    assign w_cnt_inc   = {1'b0, cnt_q} + {{c_CNT_W{1'b0}}, 1'b1};
    assign w_limit_hit = (w_cnt_inc >= {1'b0, c_LIMIT});

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_lo_d = addr_lo_q;
        size_d    = size_q;
        uns_d     = uns_q;
        store_d   = store_q;
        fin_d     = 1'b0;
        mis_d     = 1'b0;
        to_d      = 1'b0;
        regw_d    = regw_q;
        inst_d    = inst_q;
        dreq_d    = dreq_q;
        dwe_d     = dwe_q;
        daddr_d   = daddr_q;
        dwdata_d  = dwdata_q;
        dbe_d     = dbe_q;

        case (state_q)
            c_IDLE: begin
                if (enable) begin
                    inst_d    = inst;
                    addr_lo_d = alu_result[1:0];
                    size_d    = mem_size;
                    uns_d     = mem_unsigned;
                    store_d   = mem_write;
                    cnt_d     = '0;
                    if (!w_is_mem) begin
                        regw_d  = alu_result;
                        fin_d   = 1'b1;
                        state_d = c_DONE;
                    end else if (w_misal) begin
                        regw_d  = 32'h0;
                        mis_d   = 1'b1;
                        fin_d   = 1'b1;
                        state_d = c_DONE;
                    end else begin
                        // A store wins when both read and write are requested.
                        dreq_d   = 1'b1;
                        dwe_d    = mem_write;
                        daddr_d  = {alu_result[31:2], 2'b00};
                        dwdata_d = mem_write ? w_st_data : 32'h0;
                        dbe_d    = mem_write ? w_st_be : 4'b1111;
                        state_d  = c_REQ;
                    end
                end
            end

            c_REQ: begin
                if (dvalid) begin
                    dreq_d  = 1'b0;
                    fin_d   = 1'b1;
                    regw_d  = store_q ? 32'h0 : w_ld_val;
                    state_d = c_DONE;
                end else if (w_limit_hit) begin
                    dreq_d  = 1'b0;
                    fin_d   = 1'b1;
                    to_d    = 1'b1;
                    regw_d  = 32'h0;
                    state_d = c_DONE;
                end else begin
                    cnt_d = w_cnt_inc[c_CNT_W] ? cnt_q : w_cnt_inc[c_CNT_W-1:0];
                end
            end

            c_DONE: begin
                state_d = c_IDLE;
            end

            default: begin
                state_d = c_IDLE;
                dreq_d  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q   <= c_IDLE;
            cnt_q     <= '0;
            addr_lo_q <= 2'b00;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            store_q   <= 1'b0;
            fin_q     <= 1'b0;
            mis_q     <= 1'b0;
            to_q      <= 1'b0;
            regw_q    <= 32'h0;
            inst_q    <= '0;
            dreq_q    <= 1'b0;
            dwe_q     <= 1'b0;
            daddr_q   <= 32'h0;
            dwdata_q  <= 32'h0;
            dbe_q     <= 4'b0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_lo_q <= addr_lo_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            store_q   <= store_d;
            fin_q     <= fin_d;
            mis_q     <= mis_d;
            to_q      <= to_d;
            regw_q    <= regw_d;
            inst_q    <= inst_d;
            dreq_q    <= dreq_d;
            dwe_q     <= dwe_d;
            daddr_q   <= daddr_d;
            dwdata_q  <= dwdata_d;
            dbe_q     <= dbe_d;
        end
    end

    assign fin          = fin_q;
    assign misaligned   = mis_q;
    assign timeout      = to_q;
    assign regwdata_out = regw_q;
    assign inst_out     = inst_q;
    assign dreq         = dreq_q;
    assign dwe          = dwe_q;
    assign daddr        = daddr_q;
    assign dwdata       = dwdata_q;
    assign dbe          = dbe_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Directed self-checking bench for mem_stage; expected results
//               are queued at issue and compared when fin is observed.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_stage;

    localparam int c_TO = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic        fin;
    logic [31:0] inst;
    logic [31:0] inst_out;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] regwdata_out;
    logic        misaligned;
    logic        timeout;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  dbe;
    logic        dvalid;
    logic [31:0] drdata;

    mem_stage #(
        .TIMEOUT_CYCLES(c_TO),
        .INST_W        (32)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .enable      (enable),
        .fin         (fin),
        .inst        (inst),
        .inst_out    (inst_out),
        .alu_result  (alu_result),
        .store_data  (store_data),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_size    (mem_size),
        .mem_unsigned(mem_unsigned),
        .regwdata_out(regwdata_out),
        .misaligned  (misaligned),
        .timeout     (timeout),
        .dreq        (dreq),
        .dwe         (dwe),
        .daddr       (daddr),
        .dwdata      (dwdata),
        .dbe         (dbe),
        .dvalid      (dvalid),
        .drdata      (drdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] regw;
        logic        mis;
        logic        to;
        logic [31:0] inst;
        int          lat;
        int          dreq_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one operation, optionally return dvalid at observation cycle dv_at
    // (0 = never), and compare against the queued expectation on fin.
    task automatic run_op(
        input string       name,
        input logic [31:0] ins,
        input logic        rd,
        input logic        wr,
        input logic [1:0]  sz,
        input logic        uns,
        input logic [31:0] addr,
        input logic [31:0] sd,
        input logic [31:0] rdata,
        input int          dv_at,
        input logic        poke,
        input logic [31:0] x_regw,
        input logic        x_mis,
        input logic        x_to,
        input int          x_lat,
        input int          x_dreq,
        input logic [31:0] x_daddr,
        input logic        x_dwe,
        input logic [3:0]  x_dbe,
        input logic [31:0] x_dwdata
    );
        exp_t e;
        int   c;
        int   dcyc;
        e.regw     = x_regw;
        e.mis      = x_mis;
        e.to       = x_to;
        e.inst     = ins;
        e.lat      = x_lat;
        e.dreq_cyc = x_dreq;
        exp_q.push_back(e);

        inst         = ins;
        alu_result   = addr;
        store_data   = sd;
        mem_read     = rd;
        mem_write    = wr;
        mem_size     = sz;
        mem_unsigned = uns;
        enable       = 1'b1;
        step();
        enable = 1'b0;
        c      = 1;
        dcyc   = 0;
        while (fin !== 1'b1 && c < 40) begin
            if (dreq === 1'b1) begin
                dcyc++;
                chk({name, "_daddr"}, daddr, x_daddr);
                chk({name, "_dwe"}, {31'h0, dwe}, {31'h0, x_dwe});
                chk({name, "_dbe"}, {28'h0, dbe}, {28'h0, x_dbe});
                if (x_dwe) chk({name, "_dwdata"}, dwdata, x_dwdata);
            end
            if (poke) begin
                // Junk request while busy; must not disturb the op in flight.
                enable     = 1'b1;
                inst       = ~ins;
                alu_result = 32'hFFFF_FFF0;
            end
            if (c == dv_at) begin
                dvalid = 1'b1;
                drdata = rdata;
            end
            step();
            dvalid = 1'b0;
            drdata = 32'h0;
            enable = 1'b0;
            c++;
        end

        e = exp_q.pop_front();
        chk({name, "_latency"}, c, e.lat);
        chk({name, "_dreq_cycles"}, dcyc, e.dreq_cyc);
        chk({name, "_regw"}, regwdata_out, e.regw);
        chk({name, "_misaligned"}, {31'h0, misaligned}, {31'h0, e.mis});
        chk({name, "_timeout"}, {31'h0, timeout}, {31'h0, e.to});
        chk({name, "_inst_out"}, inst_out, e.inst);
        step();
        chk({name, "_fin_pulse"}, {31'h0, fin}, 32'h0);
        chk({name, "_dreq_after"}, {31'h0, dreq}, 32'h0);
        chk({name, "_regw_hold"}, regwdata_out, e.regw);
    endtask

    initial begin
        rstn         = 1'b1;
        enable       = 1'b0;
        inst         = 32'hCAFE_0001;
        alu_result   = 32'hFFFF_FFFF;
        store_data   = 32'hFFFF_FFFF;
        mem_read     = 1'b1;
        mem_write    = 1'b1;
        mem_size     = 2'b10;
        mem_unsigned = 1'b0;
        dvalid       = 1'b0;
        drdata       = 32'h0;
        step();
        step();
        chk("rst_fin", {31'h0, fin}, 32'h0);
        chk("rst_dreq", {31'h0, dreq}, 32'h0);
        chk("rst_dwe", {31'h0, dwe}, 32'h0);
        chk("rst_dbe", {28'h0, dbe}, 32'h0);
        chk("rst_daddr", daddr, 32'h0);
        chk("rst_dwdata", dwdata, 32'h0);
        chk("rst_regw", regwdata_out, 32'h0);
        chk("rst_mis", {31'h0, misaligned}, 32'h0);
        chk("rst_to", {31'h0, timeout}, 32'h0);
        chk("rst_inst", inst_out, 32'h0);
        rstn = 1'b0;
        step();

        //      name        inst          rd    wr    sz     uns   addr          sd            rdata         dv poke  regw          mis   to    lat dreq daddr         dwe   dbe      dwdata
        run_op("nonmem",    32'h0000_0011, 1'b0, 1'b0, 2'b10, 1'b0, 32'h1234_5678, 32'h0,        32'h0,        0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 1, 0, 32'h0,         1'b0, 4'hF,    32'h0);
        run_op("lb_signed", 32'h0000_0022, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,        32'h80AA_BBCC, 3, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b0, 4, 3, 32'h0000_0100, 1'b0, 4'hF,    32'h0);
        run_op("sh",        32'h0000_0033, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_BEEF, 32'h1111_1111, 1, 1'b0, 32'h0,        1'b0, 1'b0, 2, 1, 32'h0000_0200, 1'b1, 4'b1100, 32'hBEEF_BEEF);
        run_op("lw_misal",  32'h0000_0044, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0,        32'h0,        0, 1'b0, 32'h0,        1'b1, 1'b0, 1, 0, 32'h0,         1'b0, 4'hF,    32'h0);
        run_op("timeout",   32'h0000_0055, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0,        32'h0,        0, 1'b0, 32'h0,        1'b0, 1'b1, 5, 4, 32'h0000_0300, 1'b0, 4'hF,    32'h0);
        run_op("dv_at_lim", 32'h0000_0066, 1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0304, 32'h0,        32'hDEAD_BEEF, 4, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 5, 4, 32'h0000_0304, 1'b0, 4'hF,    32'h0);
        run_op("lhu",       32'h0000_0077, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0402, 32'h0,        32'h9234_5678, 2, 1'b0, 32'h0000_9234, 1'b0, 1'b0, 3, 2, 32'h0000_0400, 1'b0, 4'hF,    32'h0);
        run_op("lh_signed", 32'h0000_0088, 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0400, 32'h0,        32'h1234_8001, 1, 1'b0, 32'hFFFF_8001, 1'b0, 1'b0, 2, 1, 32'h0000_0400, 1'b0, 4'hF,    32'h0);
        run_op("sb_rdwr",   32'h0000_0099, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0501, 32'h1234_56AB, 32'h7777_7777, 1, 1'b0, 32'h0,        1'b0, 1'b0, 2, 1, 32'h0000_0500, 1'b1, 4'b0010, 32'hABAB_ABAB);
        run_op("sh_misal",  32'h0000_00AA, 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0203, 32'h0000_1234, 32'h0,        0, 1'b0, 32'h0,        1'b1, 1'b0, 1, 0, 32'h0,         1'b0, 4'hF,    32'h0);
        run_op("sw",        32'h0000_00BB, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0608, 32'h0BAD_F00D, 32'h0,        2, 1'b0, 32'h0,        1'b0, 1'b0, 3, 2, 32'h0000_0608, 1'b1, 4'hF,    32'h0BAD_F00D);
        run_op("lbu",       32'h0000_00CC, 1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0701, 32'h0,        32'h1122_F344, 1, 1'b0, 32'h0000_00F3, 1'b0, 1'b0, 2, 1, 32'h0000_0700, 1'b0, 4'hF,    32'h0);

        // Reset while a load is outstanding; the late dvalid must be ignored.
        inst         = 32'h0000_00DD;
        alu_result   = 32'h0000_0800;
        mem_read     = 1'b1;
        mem_write    = 1'b0;
        mem_size     = 2'b10;
        mem_unsigned = 1'b0;
        enable       = 1'b1;
        step();
        enable = 1'b0;
        chk("rstreq_dreq_up", {31'h0, dreq}, 32'h1);
        step();
        rstn = 1'b1;
        step();
        rstn = 1'b0;
        chk("rstreq_dreq_drop", {31'h0, dreq}, 32'h0);
        chk("rstreq_inst_clr", inst_out, 32'h0);
        dvalid = 1'b1;
        drdata = 32'h5555_AAAA;
        step();
        dvalid = 1'b0;
        drdata = 32'h0;
        chk("rstreq_no_fin0", {31'h0, fin}, 32'h0);
        chk("rstreq_regw", regwdata_out, 32'h0);
        step();
        chk("rstreq_no_fin1", {31'h0, fin}, 32'h0);
        chk("rstreq_dreq_idle", {31'h0, dreq}, 32'h0);
        run_op("post_rst",  32'h0000_00EE, 1'b0, 1'b0, 2'b00, 1'b0, 32'hA5A5_5A5A, 32'h0,        32'h0,        0, 1'b0, 32'hA5A5_5A5A, 1'b0, 1'b0, 1, 0, 32'h0,         1'b0, 4'hF,    32'h0);

        chk("queue_empty", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
